// File: rtl/arb_req_pkg.sv
// Shared types and default sizing for the arbiter request-side controller.
// Optional wait-timeout logic is compiled in with the macro ARB_REQ_TIMEOUT_EN.
package arb_req_pkg;

  localparam int NUM_CLIENTS  = 4;
  localparam int CNT_W_DEF    = 4;
  localparam int XFER_LEN_DEF = 4;
  localparam int TIMEOUT_DEF  = 64;

  // Beat counter is wide enough for the longest legal transfer (255 cycles).
  localparam int BEAT_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2,
    REL  = 2'd3
  } client_state_t;

  // A request is presented to the arbiter while waiting and while transferring.
  function automatic logic state_requests(input client_state_t s);
    return (s == REQ) || (s == XFER);
  endfunction

endpackage

// File: rtl/arb_req_client.sv
// One client's request FSM, pending-transaction counter, beat timer and sticky flags.
// With ARB_REQ_TIMEOUT_EN defined a per-client wait counter drives tmo; otherwise tmo is 0.
module arb_req_client
  import arb_req_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEF,
  parameter int XFER_LEN = XFER_LEN_DEF,
  parameter int TIMEOUT  = TIMEOUT_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          grant,
  output logic          req,
  output logic          done,
  output logic          ovf,
  output logic          tmo,
  output client_state_t state
);

  localparam logic [CNT_W-1:0]  PEND_MAX  = {CNT_W{1'b1}};
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(XFER_LEN - 1);

  if (XFER_LEN < 1 || XFER_LEN > 255 || TIMEOUT < 1 || CNT_W < 1) begin : g_bad_param
    $error("arb_req_client: illegal parameter set");
  end

  logic [CNT_W-1:0]  pending;
  logic [CNT_W-1:0]  pending_nxt;
  logic [BEAT_W-1:0] beat;
  client_state_t     state_nxt;
  logic              dec;
  logic              ovf_set;

  // The last beat of a transfer retires one pending transaction; a push
  // landing in that same cycle cancels it out, so it is never dropped.
  always_comb begin
    dec         = (state == XFER) && (beat == BEAT_LAST);
    ovf_set     = 1'b0;
    pending_nxt = pending;
    case ({push, dec})
      2'b10: begin
        if (pending == PEND_MAX) begin
          ovf_set = 1'b1;
        end else begin
          pending_nxt = pending + CNT_W'(1);
        end
      end
      2'b01:   pending_nxt = pending - CNT_W'(1);
      default: pending_nxt = pending;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (push) state_nxt = REQ;
      REQ:     if (grant) state_nxt = XFER;
      XFER:    if (dec) state_nxt = REL;
      REL:     state_nxt = (pending_nxt != '0) ? REQ : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // req and done are registered copies of what the next state implies.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      pending <= '0;
      beat    <= '0;
      req     <= 1'b0;
      done    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      state   <= state_nxt;
      pending <= pending_nxt;
      if (state == REQ && grant) begin
        beat <= '0;
      end else if (state == XFER) begin
        beat <= beat + BEAT_W'(1);
      end
      req <= state_requests(state_nxt);
      done <= (state_nxt == REL);
      if (ovf_set) begin
        ovf <= 1'b1;
      end
    end
  end

`ifdef ARB_REQ_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  logic [WAIT_W-1:0] wait_cnt;

  // Counts cycles spent in REQ; saturates so it never wraps back below the limit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
      tmo      <= 1'b0;
    end else begin
      if (state != REQ && state_nxt == REQ) begin
        wait_cnt <= '0;
      end else if (state == REQ && wait_cnt != WAIT_MAX) begin
        wait_cnt <= wait_cnt + WAIT_W'(1);
      end
      if (state == REQ && wait_cnt == WAIT_LAST) begin
        tmo <= 1'b1;
      end
    end
  end
`else
  assign tmo = 1'b0;
`endif

endmodule

// File: rtl/arb_req_ctrl.sv
// Request-side controller for a 4-client arbiter: four client FSMs plus grant-protocol checking.
// Wait-timeout flags on tmo are built only when ARB_REQ_TIMEOUT_EN is defined.
module arb_req_ctrl
  import arb_req_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEF,
  parameter int XFER_LEN = XFER_LEN_DEF,
  parameter int TIMEOUT  = TIMEOUT_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push_a,
  input  logic       push_b,
  input  logic       push_c,
  input  logic       push_d,
  input  logic       ga,
  input  logic       gb,
  input  logic       gc,
  input  logic       gd,
  output logic       ra,
  output logic       rb,
  output logic       rc,
  output logic       rd,
  output logic       done_a,
  output logic       done_b,
  output logic       done_c,
  output logic       done_d,
  output logic [3:0] ovf,
  output logic       proto_err,
  output logic [3:0] tmo
);

  logic [NUM_CLIENTS-1:0] push_v;
  logic [NUM_CLIENTS-1:0] grant_v;
  logic [NUM_CLIENTS-1:0] req_v;
  logic [NUM_CLIENTS-1:0] done_v;
  logic [NUM_CLIENTS-1:0] viol;
  logic                   multi_grant;
  client_state_t          client_state [NUM_CLIENTS];

  assign push_v  = {push_d, push_c, push_b, push_a};
  assign grant_v = {gd, gc, gb, ga};

  assign {rd, rc, rb, ra}             = req_v;
  assign {done_d, done_c, done_b, done_a} = done_v;

  for (genvar i = 0; i < NUM_CLIENTS; i++) begin : g_client
    arb_req_client #(
      .CNT_W    (CNT_W),
      .XFER_LEN (XFER_LEN),
      .TIMEOUT  (TIMEOUT)
    ) u_client (
      .clk   (clk),
      .reset (reset),
      .push  (push_v[i]),
      .grant (grant_v[i]),
      .req   (req_v[i]),
      .done  (done_v[i]),
      .ovf   (ovf[i]),
      .tmo   (tmo[i]),
      .state (client_state[i])
    );
  end

  // A grant is illegal toward a client that is not asking, and must not
  // disappear while that client is mid-transfer.
  always_comb begin
    viol = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      case (client_state[i])
        IDLE, REL: viol[i] = grant_v[i];
        XFER:      viol[i] = !grant_v[i];
        default:   viol[i] = 1'b0;
      endcase
    end
  end

  assign multi_grant = (grant_v & (grant_v - 4'd1)) != 4'd0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      proto_err <= 1'b0;
    end else if (multi_grant || (viol != '0)) begin
      proto_err <= 1'b1;
    end
  end

endmodule
